// File: rtl/mem_fifo_pkg.sv
// Shared constants for the packet-RAM FIFO controller and its prefetch buffer.
package mem_fifo_pkg;

    localparam int DATA_W     = 64;          // payload width, matches the RAM word
    localparam int DEPTH      = 4;           // RAM entries
    localparam int ADDR_W     = 2;           // log2(DEPTH)
    localparam int RD_LAT     = 2;           // clocks from mem_rd_en sample to valid mem_rd_data
    localparam int OBUF_DEPTH = RD_LAT + 2;  // prefetch buffer entries

    localparam int MEM_CNT_W  = 3;           // holds 0..DEPTH
    localparam int OBUF_CNT_W = 3;           // holds 0..OBUF_DEPTH
    localparam int LEVEL_W    = 4;           // holds 0..DEPTH+OBUF_DEPTH

    localparam logic [MEM_CNT_W-1:0]  MEM_FULL  = MEM_CNT_W'(DEPTH);
    localparam logic [OBUF_CNT_W-1:0] OBUF_FULL = OBUF_CNT_W'(OBUF_DEPTH);

    // Number of reads currently travelling through the RAM pipeline.
    function automatic logic [OBUF_CNT_W-1:0] count_ones(input logic [RD_LAT-1:0] bits);
        logic [OBUF_CNT_W-1:0] total;
        total = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            total = total + OBUF_CNT_W'(bits[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/mem_rd_prefetch_buf.sv
// Small register FIFO that catches RAM read data and presents a zero-latency head.
// The controller's credit accounting guarantees a push never meets a full buffer.
module mem_rd_prefetch_buf
    import mem_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head_data,
    output logic [OBUF_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(OBUF_DEPTH);

    logic [DATA_W-1:0] entries [OBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop    = pop && (count != '0);
    assign do_push   = push && (count != OBUF_FULL);
    assign head_data = entries[rd_ptr];

    // Storage, pointers and occupancy; push and pop in one cycle are both honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OBUF_CNT_W'(1);
                2'b01:   count <= count - OBUF_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller owning both ports of the 4x64 packet RAM. Writes go straight
// to the RAM; reads are issued ahead of demand into a prefetch buffer so the
// consumer sees a zero-latency stream despite the RAM's fixed read latency.
//
// Handshakes: a word moves on a port exactly on a clock edge where valid and
// ready are both 1. in_ready and out_valid depend only on registered state
// (and rst), never on the partner's valid/ready in the same cycle.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               mem_wr_en,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [DATA_W-1:0]  mem_wr_data,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic [LEVEL_W-1:0] level
);

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [MEM_CNT_W-1:0]  mem_count;
    logic [RD_LAT-1:0]     rd_pipe;
    logic [OBUF_CNT_W-1:0] inflight;
    logic [OBUF_CNT_W-1:0] obuf_count;
    logic                  accept;
    logic                  issue;
    logic                  land;
    logic                  pop;

    // mem_count excludes this cycle's write, so a slot is never read while written.
    assign in_ready    = !rst && (mem_count != MEM_FULL);
    assign accept      = in_valid && in_ready;
    assign mem_wr_en   = accept;
    assign mem_wr_addr = wr_ptr;
    assign mem_wr_data = in_data;

    // Issue only when the buffer has a guaranteed slot for every read in flight.
    assign inflight    = count_ones(rd_pipe);
    assign issue       = !rst && (mem_count != '0) && ((obuf_count + inflight) < OBUF_FULL);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_ptr;

    // The oldest pipe bit marks a cycle where RAM read data is valid.
    assign land      = rd_pipe[RD_LAT-1];
    assign out_valid = (obuf_count != '0);
    assign pop       = out_valid && out_ready;

    assign level = LEVEL_W'(mem_count) + LEVEL_W'(inflight) + LEVEL_W'(obuf_count);

    // Pointers, RAM occupancy and the in-flight read valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_pipe   <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({accept, issue})
                2'b10:   mem_count <= mem_count + MEM_CNT_W'(1);
                2'b01:   mem_count <= mem_count - MEM_CNT_W'(1);
                default: mem_count <= mem_count;
            endcase
            rd_pipe <= {rd_pipe[RD_LAT-2:0], issue};
        end
    end

    mem_rd_prefetch_buf u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (land),
        .push_data (mem_rd_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (obuf_count)
    );

endmodule
